// File: rtl/rgmii_link_mdio_poll_if.sv
// MDIO pin bundle between the management master and the PHY pad/model.
// Latency: none, plain wires.
// Backpressure: none; MDIO is a master-clocked serial bus.
interface rgmii_link_mdio_poll_if;
    logic mdc;
    logic mdio_i;
    logic mdio_o;
    logic mdio_t;

    modport master (output mdc, output mdio_o, output mdio_t, input mdio_i);
    modport slave  (input mdc, input mdio_o, input mdio_t, output mdio_i);
endinterface

// File: rtl/rgmii_link_mdio_poll.sv
// Periodic MDIO read of the PHY status register; decodes link, speed and duplex for the RGMII interface.
// Latency: one poll = 128*MDC_DIV clk of framing + 1 clk decode; change pulses the cycle after decode.
// Backpressure: none; poll_req during a poll is dropped, enable=0 only blocks new frames.
module rgmii_link_mdio_poll #(
    parameter int unsigned MDC_DIV       = 25,
    parameter int unsigned POLL_INTERVAL = 125000,
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter logic [4:0]  STATUS_REG    = 5'd17,
    parameter int unsigned SPEED_MSB     = 15,
    parameter int unsigned DUPLEX_BIT    = 13,
    parameter int unsigned RESOLVED_BIT  = 11,
    parameter int unsigned LINK_BIT      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        poll_req,
    rgmii_link_mdio_poll_if.master mdio,
    output logic [1:0]  speed,
    output logic        link_up,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        phy_absent,
    output logic        change,
    output logic        busy,
    output logic [15:0] status_word
);

    typedef enum logic [1:0] {IDLE, XFER, UPDATE} state_t;

    localparam logic [7:0]  DIV_LAST = 8'(MDC_DIV - 1);
    localparam logic [23:0] POLL_LD  = 24'(POLL_INTERVAL);
    // Host-driven part of the read frame, slot 0 in the MSB: preamble, ST, OP, PHYAD, REGAD.
    localparam logic [45:0] HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STATUS_REG};

    state_t      state;
    logic [7:0]  div_cnt;
    logic [5:0]  slot;
    logic [23:0] timer;
    logic [15:0] shreg;
    logic        mdc_q;
    logic        mdio_o_q;
    logic        mdio_t_q;

    logic [5:0]  nxt_slot;
    logic [1:0]  fld;
    logic        upd_absent;
    logic        upd_link;
    logic [1:0]  upd_speed;
    logic        upd_dup;

    assign mdio.mdc    = mdc_q;
    assign mdio.mdio_o = mdio_o_q;
    assign mdio.mdio_t = mdio_t_q;

    // Bit the master drives in a given slot; turnaround and data slots idle high.
    function automatic logic hdr_bit(input logic [5:0] s);
        if (s > 6'd45) begin
            return 1'b1;
        end
        return HDR[6'd45 - s];
    endfunction

    // Decode of the freshly shifted word, applied in UPDATE.
    always_comb begin
        nxt_slot   = slot + 6'd1;
        fld        = shreg[SPEED_MSB -: 2];
        upd_absent = (shreg == 16'hFFFF);
        upd_link   = 1'b0;
        upd_speed  = speed;
        upd_dup    = full_duplex;
        if (!upd_absent) begin
            upd_link = shreg[LINK_BIT] & shreg[RESOLVED_BIT];
            // Reserved speed code or unresolved autoneg keeps the last good setting.
            if (upd_link && fld != 2'b11) begin
                upd_speed = fld;
                upd_dup   = shreg[DUPLEX_BIT];
            end
        end
    end

    // Poll scheduler, MDC/MDIO framing and status decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= 8'd0;
            slot         <= 6'd0;
            timer        <= 24'd0;
            shreg        <= 16'd0;
            mdc_q        <= 1'b0;
            mdio_o_q     <= 1'b1;
            mdio_t_q     <= 1'b1;
            speed        <= 2'b10;
            link_up      <= 1'b0;
            full_duplex  <= 1'b0;
            status_valid <= 1'b0;
            phy_absent   <= 1'b0;
            change       <= 1'b0;
            busy         <= 1'b0;
            status_word  <= 16'd0;
        end else begin
            change <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (timer == 24'd0 || poll_req)) begin
                        state    <= XFER;
                        busy     <= 1'b1;
                        slot     <= 6'd0;
                        div_cnt  <= 8'd0;
                        mdc_q    <= 1'b0;
                        mdio_o_q <= hdr_bit(6'd0);
                        mdio_t_q <= 1'b0;
                    end else if (timer != 24'd0) begin
                        timer <= timer - 24'd1;
                    end
                end
                XFER: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!mdc_q) begin
                            // Rising MDC: PHY data is stable from the preceding low half.
                            mdc_q <= 1'b1;
                            if (slot >= 6'd48) begin
                                shreg <= {shreg[14:0], mdio.mdio_i};
                            end
                        end else begin
                            mdc_q <= 1'b0;
                            if (slot == 6'd63) begin
                                mdio_o_q <= 1'b1;
                                mdio_t_q <= 1'b1;
                                state    <= UPDATE;
                            end else begin
                                slot     <= nxt_slot;
                                mdio_o_q <= hdr_bit(nxt_slot);
                                mdio_t_q <= (nxt_slot >= 6'd46);
                            end
                        end
                    end
                end
                UPDATE: begin
                    status_word <= shreg;
                    phy_absent  <= upd_absent;
                    link_up     <= upd_link;
                    speed       <= upd_speed;
                    full_duplex <= upd_dup;
                    if (!upd_absent) begin
                        status_valid <= 1'b1;
                    end
                    change <= (upd_speed != speed) || (upd_link != link_up);
                    timer  <= POLL_LD;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_link_mdio_poll.sv
module tb_rgmii_link_mdio_poll;
    localparam int D       = 2;
    localparam int PI      = 10;
    localparam int FRAME   = 128 * D + 1;
    localparam int SPACING = 128 * D + 1 + PI + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        poll_req = 1'b0;
    logic [1:0]  speed;
    logic        link_up, full_duplex, status_valid, phy_absent, change, busy;
    logic [15:0] status_word;

    rgmii_link_mdio_poll_if mdio_bus();

    rgmii_link_mdio_poll #(
        .MDC_DIV(D), .POLL_INTERVAL(PI), .PHY_ADDR(5'd0), .STATUS_REG(5'd17),
        .SPEED_MSB(15), .DUPLEX_BIT(13), .RESOLVED_BIT(11), .LINK_BIT(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .poll_req(poll_req),
        .mdio(mdio_bus),
        .speed(speed), .link_up(link_up), .full_duplex(full_duplex),
        .status_valid(status_valid), .phy_absent(phy_absent), .change(change),
        .busy(busy), .status_word(status_word)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // PHY model and bus monitor, evaluated on the falling clk edge.
    logic [15:0] phy_word = 16'hFFFF;
    int          phy_slot = 0;
    int          rise_cnt = 0;
    time         t_rise = 0, prev_rise = 0, t_fall = 0, t_mdc0 = 0, t_mdc1 = 0;
    logic [63:0] host_o = '0, host_t = '0;
    logic        busy_d = 1'b0, mdc_d = 1'b0;

    assign mdio_bus.mdio_i = (phy_slot >= 48 && phy_slot <= 63) ? phy_word[63 - phy_slot] : 1'b1;

    always @(negedge clk) begin
        if (busy && !busy_d) begin
            prev_rise = t_rise;
            t_rise    = $time;
            phy_slot  = 0;
            rise_cnt  = 0;
        end
        if (!busy && busy_d) t_fall = $time;
        if (mdio_bus.mdc && !mdc_d) begin
            if (rise_cnt == 0) t_mdc0 = $time;
            if (rise_cnt == 1) t_mdc1 = $time;
            if (phy_slot < 64) begin
                host_o[phy_slot] = mdio_bus.mdio_o;
                host_t[phy_slot] = mdio_bus.mdio_t;
            end
            rise_cnt++;
        end
        if (!mdio_bus.mdc && mdc_d) phy_slot++;
        busy_d = busy;
        mdc_d  = mdio_bus.mdc;
    end

    // Reference model of the decoded status.
    logic [1:0] m_speed = 2'b10;
    logic       m_link = 1'b0, m_dup = 1'b0, m_valid = 1'b0, m_absent = 1'b0;
    logic [63:0] exp_o, exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_speed = 2'b10; m_link = 1'b0; m_dup = 1'b0; m_valid = 1'b0; m_absent = 1'b0;
    endtask

    task automatic model_apply(input logic [15:0] w, output logic chg);
        logic [1:0] old_s;
        logic       old_l;
        old_s = m_speed;
        old_l = m_link;
        if (w == 16'hFFFF) begin
            m_absent = 1'b1;
            m_link   = 1'b0;
        end else begin
            m_absent = 1'b0;
            m_valid  = 1'b1;
            m_link   = w[10] && w[11];
            if (m_link && w[15:14] != 2'b11) begin
                m_speed = w[15:14];
                m_dup   = w[13];
            end
        end
        chg = (m_speed != old_s) || (m_link != old_l);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < 1000) begin
            step();
            n++;
        end
        check(tag, 64'(busy), 64'(lvl));
    endtask

    task automatic do_poll(input logic [15:0] w, input string tag, input int exp_sp);
        logic chg;
        phy_word = w;
        model_apply(w, chg);
        wait_busy(1'b1, {tag, "_start"});
        wait_busy(1'b0, {tag, "_end"});
        check({tag, "_change"}, 64'(change), 64'(chg));
        check({tag, "_speed"}, 64'(speed), 64'(m_speed));
        check({tag, "_link"}, 64'(link_up), 64'(m_link));
        check({tag, "_duplex"}, 64'(full_duplex), 64'(m_dup));
        check({tag, "_valid"}, 64'(status_valid), 64'(m_valid));
        check({tag, "_absent"}, 64'(phy_absent), 64'(m_absent));
        check({tag, "_word"}, 64'(status_word), 64'(w));
        check({tag, "_busy_len"}, 64'((t_fall - t_rise) / 10), 64'(FRAME));
        check({tag, "_slots"}, 64'(rise_cnt), 64'd64);
        check({tag, "_mdc_period"}, 64'((t_mdc1 - t_mdc0) / 10), 64'(2 * D));
        check({tag, "_mdio_t"}, host_t, exp_t);
        check({tag, "_mdio_o"}, 64'(host_o[45:0]), 64'(exp_o[45:0]));
        if (exp_sp != 0) check({tag, "_spacing"}, 64'((t_rise - prev_rise) / 10), 64'(exp_sp));
        step();
        check({tag, "_change_width"}, 64'(change), 64'd0);
    endtask

    initial begin
        logic [15:0] w;
        logic [4:0]  pa, ra;
        int          n, hi;

        pa = 5'd0;
        ra = 5'd17;
        exp_o = '1;
        exp_t = '0;
        for (int s = 46; s < 64; s++) exp_t[s] = 1'b1;
        exp_o[32] = 1'b0; exp_o[33] = 1'b1; exp_o[34] = 1'b1; exp_o[35] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_o[36 + i] = pa[4 - i];
            exp_o[41 + i] = ra[4 - i];
        end

        // Reset state.
        repeat (3) step();
        check("rst_mdc", 64'(mdio_bus.mdc), 64'd0);
        check("rst_mdio_o", 64'(mdio_bus.mdio_o), 64'd1);
        check("rst_mdio_t", 64'(mdio_bus.mdio_t), 64'd1);
        check("rst_speed", 64'(speed), 64'(2'b10));
        check("rst_flags", 64'({link_up, full_duplex, status_valid, phy_absent, change, busy}), 64'd0);
        check("rst_word", 64'(status_word), 64'd0);

        rst_n = 1'b1;
        repeat (5) step();
        check("idle_disabled", 64'(busy), 64'd0);

        // First poll begins on the first edge with enable high.
        enable = 1'b1;
        step();
        check("first_start", 64'(busy), 64'd1);
        do_poll(16'hAC00, "p_ac00", 0);
        do_poll(16'h4C00, "p_4c00", SPACING);
        do_poll(16'h4C00, "p_4c00_again", SPACING);
        do_poll(16'h0000, "p_down", SPACING);
        do_poll(16'h8800, "p_nolink", SPACING);
        do_poll(16'hFFFF, "p_float", SPACING);
        do_poll(16'h4C00, "p_back", SPACING);

        for (int k = 0; k < 8; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) != 0) w[11:10] = 2'b11;
            if ($urandom_range(0, 7) == 0) w = 16'hFFFF;
            do_poll(w, $sformatf("rnd%0d", k), SPACING);
        end

        // poll_req in IDLE starts at once; a second one during the frame is dropped.
        step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        check("preq_start", 64'(busy), 64'd1);
        repeat (20) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        do_poll(16'h2C00, "p_preq", 0);
        do_poll(16'hAC00, "p_after_preq", SPACING);

        // enable dropped mid-frame: frame and decode finish, nothing follows.
        phy_word = 16'h6C00;
        wait_busy(1'b1, "en_wait");
        repeat (30) step();
        enable = 1'b0;
        do_poll(16'h6C00, "p_en_drop", 0);
        hi = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (busy) hi++;
        end
        check("disabled_no_frames", 64'(hi), 64'd0);

        // Reset in the middle of the data phase.
        enable = 1'b1;
        phy_word = 16'h4C00;
        wait_busy(1'b1, "rst_wait");
        n = 0;
        while (phy_slot < 50 && n < 1000) begin
            step();
            n++;
        end
        check("reached_slot50", 64'(phy_slot), 64'd50);
        rst_n = 1'b0;
        #1;
        check("midrst_mdc", 64'(mdio_bus.mdc), 64'd0);
        check("midrst_mdio_t", 64'(mdio_bus.mdio_t), 64'd1);
        check("midrst_speed", 64'(speed), 64'(2'b10));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_state", 64'({link_up, status_valid, status_word}), 64'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        do_poll(16'hAC00, "p_post_rst", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
